// File: rtl/fifo_dequeue_mux_if.sv
// rtl/fifo_dequeue_mux_if.sv - grant/FIFO/output bundle for fifo_dequeue_mux
//
// Purpose: groups the arbiter grant, queue FIFO read side, output stream and
// drop counter into one interface.
// Modports:
//   slave  - the dequeue mux: takes grant, FIFO flags/data and out_ready;
//            drives pop, data_out, out_id, data_valid and drop_count.
//   master - the surrounding arbiter/FIFO/consumer environment (mirror image).
interface fifo_dequeue_mux_if #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int DATA_BITS      = 8,
    parameter int DROP_BITS      = 8
);
    localparam int SEL_BITS = $clog2(QUEUE_QUANTITY);

    logic                                enb;
    logic [SEL_BITS-1:0]                 selector;
    logic                                selector_enb;
    logic [QUEUE_QUANTITY-1:0]           buf_empty;
    logic [QUEUE_QUANTITY*DATA_BITS-1:0] fifo_data;
    logic [QUEUE_QUANTITY-1:0]           pop;
    logic [DATA_BITS-1:0]                data_out;
    logic [SEL_BITS-1:0]                 out_id;
    logic                                data_valid;
    logic                                out_ready;
    logic [DROP_BITS-1:0]                drop_count;

    modport slave (
        input  enb, selector, selector_enb, buf_empty, fifo_data, out_ready,
        output pop, data_out, out_id, data_valid, drop_count
    );

    modport master (
        output enb, selector, selector_enb, buf_empty, fifo_data, out_ready,
        input  pop, data_out, out_id, data_valid, drop_count
    );
endinterface

// File: rtl/fifo_dequeue_mux.sv
// rtl/fifo_dequeue_mux.sv - pops granted queue FIFOs into a 2-entry ready/valid buffer
//
// Purpose: consumes the round-robin arbiter grant, pops the selected queue
// FIFO, captures the word one cycle later and presents it on a ready/valid
// output through a 2-entry buffer. Grants that could not be buffered are
// dropped and counted (saturating).
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - fifo_dequeue_mux_if.slave: enb, selector, selector_enb, buf_empty,
//          fifo_data, out_ready in; pop, data_out, out_id, data_valid,
//          drop_count out
module fifo_dequeue_mux #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int DATA_BITS      = 8,
    parameter int DROP_BITS      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    fifo_dequeue_mux_if.slave       bus
);
    localparam int SEL_BITS = $clog2(QUEUE_QUANTITY);
    localparam logic [DROP_BITS-1:0] DROP_MAX = {DROP_BITS{1'b1}};

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    occ_t                  occ;
    logic [DATA_BITS-1:0]  head_data;
    logic [SEL_BITS-1:0]   head_id;
    logic [DATA_BITS-1:0]  tail_data;
    logic [SEL_BITS-1:0]   tail_id;
    logic                  pend_v;
    logic [SEL_BITS-1:0]   pend_id;
    logic [DROP_BITS-1:0]  drop_cnt;

    logic [DATA_BITS-1:0]  words [QUEUE_QUANTITY];
    logic [DATA_BITS-1:0]  cap_data;
    logic [1:0]            occ_cnt;
    logic [2:0]            load;
    logic                  deq;
    logic                  room;
    logic                  grant;
    logic                  accept;
    logic                  drop;
    logic [QUEUE_QUANTITY-1:0] pop_vec;

    always_comb begin
        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            words[i] = bus.fifo_data[i*DATA_BITS +: DATA_BITS];
        end
    end

    assign cap_data = words[pend_id];

    always_comb begin
        occ_cnt = 2'd0;
        case (occ)
            OCC_ONE:  occ_cnt = 2'd1;
            OCC_FULL: occ_cnt = 2'd2;
            default:  occ_cnt = 2'd0;
        endcase
    end

    assign deq = (occ != OCC_EMPTY) && bus.out_ready;

    // Occupancy the buffer will have once the in-flight read lands and the
    // current dequeue (if any) completes; a new pop needs a free slot beyond it.
    assign load  = {1'b0, occ_cnt} + {2'b00, pend_v} - {2'b00, deq};
    assign room  = load < 3'd2;

    // rst gates grant so pop is forced low during reset.
    assign grant  = ~rst & bus.enb & bus.selector_enb & ~bus.buf_empty[bus.selector];
    assign accept = grant & room;
    assign drop   = grant & ~room;

    always_comb begin
        pop_vec = '0;
        if (accept) begin
            pop_vec[bus.selector] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ       <= OCC_EMPTY;
            head_data <= '0;
            head_id   <= '0;
            tail_data <= '0;
            tail_id   <= '0;
            pend_v    <= 1'b0;
            pend_id   <= '0;
            drop_cnt  <= '0;
        end else begin
            pend_v  <= accept;
            pend_id <= bus.selector;

            if (drop && drop_cnt != DROP_MAX) begin
                drop_cnt <= drop_cnt + 1'b1;
            end

            case (occ)
                OCC_EMPTY: begin
                    if (pend_v) begin
                        head_data <= cap_data;
                        head_id   <= pend_id;
                        occ       <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (pend_v) begin
                        if (deq) begin
                            // Head leaves as the new word arrives: it takes the head slot.
                            head_data <= cap_data;
                            head_id   <= pend_id;
                        end else begin
                            tail_data <= cap_data;
                            tail_id   <= pend_id;
                            occ       <= OCC_FULL;
                        end
                    end else if (deq) begin
                        occ <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    // The room check keeps a capture from landing on a full
                    // buffer without a dequeue; the deq+capture case is kept safe.
                    if (deq) begin
                        head_data <= tail_data;
                        head_id   <= tail_id;
                        if (pend_v) begin
                            tail_data <= cap_data;
                            tail_id   <= pend_id;
                        end else begin
                            occ <= OCC_ONE;
                        end
                    end
                end
                default: occ <= OCC_EMPTY;
            endcase
        end
    end

    assign bus.pop        = pop_vec;
    assign bus.data_out   = head_data;
    assign bus.out_id     = head_id;
    assign bus.data_valid = (occ != OCC_EMPTY);
    assign bus.drop_count = drop_cnt;

endmodule

// File: tb/tb_fifo_dequeue_mux.sv
// tb/tb_fifo_dequeue_mux.sv - self-checking bench for fifo_dequeue_mux
module tb_fifo_dequeue_mux;
    localparam int QQ  = 4;
    localparam int DB  = 8;
    localparam int DRB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_dequeue_mux_if #(.QUEUE_QUANTITY(QQ), .DATA_BITS(DB), .DROP_BITS(DRB)) bus ();

    fifo_dequeue_mux #(.QUEUE_QUANTITY(QQ), .DATA_BITS(DB), .DROP_BITS(DRB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0] id;
        logic [7:0] d;
    } entry_t;

    entry_t     mq[$];
    bit         m_pend = 1'b0;
    logic [1:0] m_pid  = 2'd0;
    int         m_drops = 0;
    int         pops_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit se, input logic [1:0] s,
                        input logic [3:0] emp, input logic [31:0] fd, input bit rdy);
        bit         dv, deq, room, grant, acc;
        logic [3:0] xp;
        entry_t     w;
        @(negedge clk);
        rst              = r;
        bus.enb          = e;
        bus.selector_enb = se;
        bus.selector     = s;
        bus.buf_empty    = emp;
        bus.fifo_data    = fd;
        bus.out_ready    = rdy;
        #1;
        if (r) begin
            mq.delete();
            m_pend  = 1'b0;
            m_drops = 0;
        end
        dv    = mq.size() > 0;
        deq   = dv && rdy;
        room  = (mq.size() + int'(m_pend) - int'(deq)) < 2;
        grant = !r && e && se && !emp[s];
        acc   = grant && room;
        xp    = acc ? (4'b0001 << s) : 4'b0000;
        check("pop", 32'(bus.pop), 32'(xp));
        check("data_valid", 32'(bus.data_valid), 32'(dv));
        if (dv) begin
            check("data_out", 32'(bus.data_out), 32'(mq[0].d));
            check("out_id", 32'(bus.out_id), 32'(mq[0].id));
        end
        if (r) begin
            check("rst_data_out", 32'(bus.data_out), 32'd0);
            check("rst_out_id", 32'(bus.out_id), 32'd0);
        end
        check("drop_count", 32'(bus.drop_count), 32'(m_drops));
        if (acc) pops_seen++;
        if (!r) begin
            if (deq) void'(mq.pop_front());
            if (m_pend) begin
                w.id = m_pid;
                w.d  = fd[int'(m_pid)*8 +: 8];
                mq.push_back(w);
            end
            if (grant && !room && m_drops < 255) m_drops++;
            m_pend = acc;
            m_pid  = s;
        end
    endtask

    initial begin
        int p0;
        bus.enb = 1'b1;
        bus.selector = 2'd0;
        bus.selector_enb = 1'b1;
        bus.buf_empty = 4'b0000;
        bus.fifo_data = '0;
        bus.out_ready = 1'b1;

        // Reset held with live grants
        for (int i = 0; i < 4; i++) step(1, 1, 1, 2'(i), 4'b0000, 32'h0, 1);

        // Single grant to queue 2
        p0 = pops_seen;
        step(0, 1, 1, 2'd2, 4'b0000, 32'h00A5_0000, 1);
        step(0, 1, 0, 2'd0, 4'b0000, 32'h00A5_0000, 1);
        step(0, 1, 0, 2'd0, 4'b0000, 32'h00A5_0000, 1);
        check("single_valid", 32'(bus.data_valid), 32'd1);
        check("single_data", 32'(bus.data_out), 32'hA5);
        check("single_id", 32'(bus.out_id), 32'd2);
        step(0, 1, 0, 2'd0, 4'b0000, 32'h0, 1);
        check("single_pops", 32'(pops_seen - p0), 32'd1);

        // Streaming over all queues
        for (int i = 0; i < 4; i++) step(0, 1, 1, 2'(i), 4'b0000, 32'h1312_1110, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 2'd0, 4'b0000, 32'h1312_1110, 1);
        check("stream_drops", 32'(bus.drop_count), 32'd0);

        // Backpressure: only two pops fit, two drops
        p0 = pops_seen;
        for (int k = 0; k < 4; k++) step(0, 1, 1, 2'd1, 4'b0000, {16'h0, 8'(8'h21 + k), 8'h0}, 0);
        for (int k = 0; k < 2; k++) step(0, 1, 0, 2'd1, 4'b0000, 32'h0, 0);
        check("bp_pops", 32'(pops_seen - p0), 32'd2);
        check("bp_drops", 32'(bus.drop_count), 32'd2);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 2'd0, 4'b0000, 32'h0, 1);

        // Grant to an empty queue, then a grant while disabled
        p0 = pops_seen;
        step(0, 1, 1, 2'd3, 4'b1000, 32'h0, 1);
        step(0, 0, 1, 2'd0, 4'b0000, 32'h0, 1);
        step(0, 1, 0, 2'd0, 4'b0000, 32'h0, 1);
        check("empty_dis_pops", 32'(pops_seen - p0), 32'd0);
        check("empty_dis_drops", 32'(bus.drop_count), 32'd2);

        // Reset landing in the capture cycle
        step(0, 1, 1, 2'd0, 4'b0000, 32'h0000_0077, 1);
        step(1, 1, 0, 2'd0, 4'b0000, 32'h0000_0077, 1);
        step(0, 1, 0, 2'd0, 4'b0000, 32'h0000_0077, 1);
        step(0, 1, 0, 2'd0, 4'b0000, 32'h0000_0077, 1);
        check("midrst_valid", 32'(bus.data_valid), 32'd0);
        check("midrst_drops", 32'(bus.drop_count), 32'd0);

        // Saturate the drop counter
        for (int k = 0; k < 300; k++) step(0, 1, 1, 2'($urandom_range(0, 3)), 4'b0000, $urandom, 0);
        check("drop_sat", 32'(bus.drop_count), 32'd255);
        step(1, 1, 0, 2'd0, 4'b0000, 32'h0, 1);

        // Randomized traffic
        for (int k = 0; k < 4000; k++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 9) < 7),
                 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                 $urandom,
                 ($urandom_range(0, 1) == 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_dequeue_mux.md
Name: fifo_dequeue_mux

Overview:
- Downstream consumer of the weighted round-robin arbiter's `selector`/`selector_enb` grant.
- On each accepted grant it pops the selected queue FIFO and captures the word (synchronous FIFO read, 1-cycle data latency).
- Presents captured words on a ready/valid output through a 2-entry output buffer.
- The arbiter has no stall input, so grants that cannot be buffered are dropped and counted.

Parameters:
- QUEUE_QUANTITY, 4, number of queue FIFOs; must be a power of 2 ≥ 2.
- DATA_BITS, 8, width of one queue word.
- DROP_BITS, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- enb  input  1  block enable; 0 = no new grants accepted.
- selector  input  $clog2(QUEUE_QUANTITY)  queue index granted by the arbiter.
- selector_enb  input  1  grant valid this cycle.
- buf_empty  input  QUEUE_QUANTITY  per-queue FIFO empty flags.
- fifo_data  input  QUEUE_QUANTITY*DATA_BITS  FIFO read data; queue i at [i*DATA_BITS +: DATA_BITS]; valid the cycle after pop[i].
- pop  output  QUEUE_QUANTITY  one-hot FIFO read strobe (combinational).
- data_out  output  DATA_BITS  head word of the output buffer.
- out_id  output  $clog2(QUEUE_QUANTITY)  source queue of data_out.
- data_valid  output  1  output buffer non-empty.
- out_ready  input  1  downstream accepts data_out this cycle.
- drop_count  output  DROP_BITS  grants lost because the buffer was full.

Behaviour:
- Reset (async, immediate):
  - Buffer emptied, pending-read register cleared.
  - data_valid=0, data_out=0, out_id=0, drop_count=0.
  - pop forced to 0 while rst=1.
- Occupancy state OCC ∈ {EMPTY, ONE, FULL}:
  - 2-entry FIFO with registered head; data_out/out_id driven from the head register.
  - data_valid = (OCC != EMPTY).
- Dequeue: `deq = data_valid & out_ready`. When deq fires, the head advances at the clock edge.
- Room check, combinational: `room = (OCC_count + pend_v - deq) < 2`, where pend_v is the pending-read valid bit.
- Grant accept in cycle N: `accept = enb & selector_enb & ~buf_empty[selector] & room`.
  - pop[selector]=1 in cycle N only.
  - pend_v=1 and pend_id=selector are registered at edge N.
- Capture in cycle N+1:
  - fifo_data[pend_id] is written into the buffer tail at edge N+1.
  - If OCC was EMPTY, or became empty through a same-cycle deq, the word becomes head: data_valid=1 and data_out is valid in cycle N+2.
  - Grant-to-data_valid latency = 2 cycles.
  - Back-to-back grants in consecutive cycles are supported (one pop per cycle sustained while out_ready=1).
- Drop: `enb & selector_enb & ~buf_empty[selector] & ~room`.
  - No pop; drop_count increments by 1 and saturates at 2^DROP_BITS-1.
- Grant to an empty queue (buf_empty[selector]=1): no pop, no drop count, no state change.
- enb=0:
  - No new accepts or drops.
  - An in-flight pending read still captures.
  - The output continues draining on out_ready.
- Simultaneous capture and deq with OCC=FULL: not possible, because room excluded the accept.
- Simultaneous capture and deq with OCC=ONE: the head is replaced by the captured word; OCC stays ONE.
- data_out/out_id must stay stable while data_valid=1 and out_ready=0.
- Reset asserted mid-operation:
  - The pending read is discarded; that FIFO word is lost (accepted).
  - Outputs return to reset values asynchronously.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 4 cycles with selector_enb=1, buf_empty=4'b0000.
  - Response: pop=0, data_valid=0, drop_count=0 throughout.
- Single grant:
  - Stimulus: selector=2, selector_enb=1 for one cycle, fifo_data queue2=8'hA5, out_ready=1.
  - Response: pop=4'b0100 in cycle N; data_valid=1, data_out=8'hA5, out_id=2 in cycle N+2 for one cycle.
- Streaming:
  - Stimulus: grants to queues 0,1,2,3 on 4 consecutive cycles, out_ready=1, each queue returning 8'h10+i.
  - Response: 4 consecutive valid outputs 8'h10..8'h13 with out_id 0..3; drop_count=0.
- Backpressure and drop:
  - Stimulus: out_ready=0 and 4 consecutive grants to queue 1.
  - Response: only 2 pops; drop_count=2; data_valid held with the first word stable.
  - Then out_ready=1 → the 2 words drain in order.
- Empty and disabled:
  - Stimulus: selector=3 with buf_empty[3]=1; then enb=0 with a valid grant.
  - Response: no pop and drop_count unchanged in both cases.
- Mid-operation reset:
  - Stimulus: assert rst in cycle N+1 after an accepted grant.
  - Response: data_valid stays 0 after reset release; drop_count=0.
